// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states,
// iterative-datapath modes and divide-by-zero result constants.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_EQ  = 4'b1010;
  localparam logic [3:0] OP_NE  = 4'b1011;
  localparam logic [3:0] OP_GT  = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b1101;
  localparam logic [3:0] OP_GE  = 4'b1110;
  localparam logic [3:0] OP_LT  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_MOD = 2'd2
  } iter_mode_e;

  // DIV by zero returns a quotient with every bit set; MOD by zero returns A.
  localparam logic DIVZ_QUOT_BIT = 1'b1;
  localparam logic DIVZ_FLAG     = 1'b1;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the operand stage, the ALU and writeback.
interface alu_mc_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Cond;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             Zero;
  logic             Carry;
  logic             DivZero;

  modport master (
    output in_valid, A, B, Cond, out_ready,
    input  in_ready, out_valid, Z, Zero, Carry, DivZero
  );

  modport slave (
    input  in_valid, A, B, Cond, out_ready,
    output in_ready, out_valid, Z, Zero, Carry, DivZero
  );

endinterface

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one bit per step.
// done_o/result_o describe the step being taken this cycle so the caller can register it.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  iter_mode_e       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc: product (MUL) or partial remainder (DIV/MOD).
  // sha: multiplicand, or dividend shifting out while quotient shifts in.
  // shb: multiplier, or divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  iter_mode_e       mode_q, mode_d;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;

  // Load on start, otherwise advance one multiply or divide step.
  always_comb begin
    acc_d   = acc_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    trial_s = {acc_q, sha_q[WIDTH-1]};
    diff_s  = trial_s - {1'b0, shb_q};
    fits_s  = (trial_s >= {1'b0, shb_q});
    if (start_i) begin
      acc_d  = {WIDTH{1'b0}};
      sha_d  = a_i;
      shb_d  = b_i;
      cnt_d  = {CW{1'b0}};
      mode_d = mode_i;
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (mode_q == IT_MUL) begin
        acc_d = acc_q + (shb_q[0] ? sha_q : {WIDTH{1'b0}});
        sha_d = sha_q << 1;
        shb_d = shb_q >> 1;
      end else begin
        acc_d = fits_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
        sha_d = {sha_q[WIDTH-2:0], fits_s};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign done_o = step_i && (cnt_q == CW'(WIDTH - 1));

  // Result of the current step: quotient lives in sha, product/remainder in acc.
  always_comb begin
    result_o = acc_d;
    case (mode_q)
      IT_MUL:  result_o = acc_d;
      IT_DIV:  result_o = sha_d;
      IT_MOD:  result_o = acc_d;
      default: result_o = acc_d;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= {WIDTH{1'b0}};
      sha_q  <= {WIDTH{1'b0}};
      shb_q  <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      mode_q <= IT_MUL;
    end else begin
      acc_q  <= acc_d;
      sha_q  <= sha_d;
      shb_q  <= shb_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, registered result and flags, one op in flight.
// Single-cycle ops finish at the accept edge; MUL/DIV/MOD run on alu_mc_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mc_if.slave  alu_if
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             divz_q, divz_d;
  logic             start_s;
  logic             step_s;
  iter_mode_e       mode_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_res_s;
  logic [WIDTH:0]   single_s;

  // Returns {carry, result} for every op that completes in one cycle.
  function automatic logic [WIDTH:0] single_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = {(WIDTH+1){1'b0}};
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_OR:   r = {1'b0, a | b};
      OP_NOT:  r = {1'b0, ~a};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {1'b0, (b >= WIDTH'(WIDTH)) ? {WIDTH{1'b0}} : (a << b)};
      OP_SHR:  r = {1'b0, (b >= WIDTH'(WIDTH)) ? {WIDTH{1'b0}} : (a >> b)};
      OP_EQ:   r = (WIDTH+1)'(a == b);
      OP_NE:   r = (WIDTH+1)'(a != b);
      OP_GT:   r = (WIDTH+1)'(a > b);
      OP_AND:  r = {1'b0, a & b};
      OP_GE:   r = (WIDTH+1)'(a >= b);
      OP_LT:   r = (WIDTH+1)'(a < b);
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_s),
    .step_i   (step_s),
    .mode_i   (mode_s),
    .a_i      (alu_if.A),
    .b_i      (alu_if.B),
    .done_o   (iter_done_s),
    .result_o (iter_res_s)
  );

  // Next state, iterator control and next result/flags.
  always_comb begin
    state_d  = state_q;
    z_d      = z_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    divz_d   = divz_q;
    start_s  = 1'b0;
    step_s   = 1'b0;
    mode_s   = IT_MUL;
    single_s = single_op(alu_if.Cond, alu_if.A, alu_if.B);
    case (state_q)
      IDLE: begin
        if (alu_if.in_valid) begin
          if (alu_if.Cond == OP_MUL) begin
            start_s = 1'b1;
            mode_s  = IT_MUL;
            state_d = MUL;
          end else if ((alu_if.Cond == OP_DIV) || (alu_if.Cond == OP_MOD)) begin
            if (alu_if.B == {WIDTH{1'b0}}) begin
              z_d     = (alu_if.Cond == OP_DIV) ? {WIDTH{DIVZ_QUOT_BIT}} : alu_if.A;
              zero_d  = (z_d == {WIDTH{1'b0}});
              carry_d = 1'b0;
              divz_d  = DIVZ_FLAG;
              state_d = DONE;
            end else begin
              start_s = 1'b1;
              mode_s  = (alu_if.Cond == OP_DIV) ? IT_DIV : IT_MOD;
              state_d = DIV;
            end
          end else begin
            z_d     = single_s[WIDTH-1:0];
            zero_d  = (single_s[WIDTH-1:0] == {WIDTH{1'b0}});
            carry_d = single_s[WIDTH];
            divz_d  = 1'b0;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        step_s = 1'b1;
        if (iter_done_s) begin
          z_d     = iter_res_s;
          zero_d  = (iter_res_s == {WIDTH{1'b0}});
          carry_d = 1'b0;
          divz_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (alu_if.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      z_q     <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      divz_q  <= divz_d;
    end
  end

  assign alu_if.in_ready  = (state_q == IDLE);
  assign alu_if.out_valid = (state_q == DONE);
  assign alu_if.Z         = z_q;
  assign alu_if.Zero      = zero_q;
  assign alu_if.Carry     = carry_q;
  assign alu_if.DivZero   = divz_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor of the 32-bit combinational ALU. It keeps the same 4-bit Cond operation encoding.
- Adds a valid/ready handshake on input and output, and registered results and flags.
- MUL, DIV and MOD use iterative shift-add / restoring datapaths instead of single-cycle `*`, `/` and `%`.
- Sits between the operand/register stage and writeback. One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4)
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept (high only in IDLE)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cond  in  4  op select
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- Z  out  WIDTH  result
- Zero  out  1  Z == 0
- Carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops
- DivZero  out  1  DIV/MOD with B == 0

Behaviour:
- Op encoding (Cond):
  - 0000 ADD, 0001 SUB, 0010 MUL (low WIDTH bits), 0011 DIV, 0100 MOD
  - 0101 OR, 0110 NOT A, 0111 XOR, 1000 SHL A<<B, 1001 SHR A>>B (logical)
  - 1010 EQ, 1011 NE, 1100 GT, 1101 AND, 1110 GE, 1111 LT
  - All 16 codes are defined; there is no default path.
- Compare results: 1-bit, unsigned, zero-extended to WIDTH.
- Shifts: B ≥ WIDTH gives Z = 0.
- Reset:
  - state=IDLE; in_ready=1 after reset; out_valid=0; Z=0; Zero=0; Carry=0; DivZero=0.
  - Counter and internal registers are cleared.
  - Reset mid-operation aborts the op with no output.
  - Reset wins over every other event in the same cycle.
- Accept: on a rising edge with state==IDLE and in_valid=1, A, B and Cond are latched. Later input changes have no effect.
- FSM:
  - IDLE -> DONE for single-cycle ops. Z and flags are registered at the accept edge; out_valid=1 in the following cycle (latency 1).
  - IDLE -> MUL. acc=0, mcand=A, mplier=B, cnt=0. Each edge: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++. After WIDTH steps -> DONE, Z=acc. Latency WIDTH+1 edges from accept to out_valid.
  - IDLE -> DIV for DIV/MOD with B≠0. Restoring division, one quotient bit per edge, MSB first, WIDTH steps -> DONE. Z = quotient (DIV) or remainder (MOD). Latency WIDTH+1.
  - DIV/MOD with B==0: no iteration, DONE next edge. Z = all-ones (DIV) or A (MOD); DivZero=1. Latency 1.
  - DONE: outputs held stable while out_valid=1 and out_ready=0. When out_ready=1, out_valid drops and state -> IDLE on that edge.
- in_ready is low during MUL/DIV/DONE; in_valid in those states is ignored.
- Zero, Carry and DivZero update together with Z and are valid only while out_valid=1.
- No back-to-back overlap: the earliest next accept is the cycle after the result handshake.

Decomposition:
- Package alu_mc_pkg holds:
  - op-code localparams (OP_ADD … OP_LT)
  - FSM state enum {IDLE, MUL, DIV, DONE}
  - DIV-by-zero result constants
- One sub-module, alu_mc_iter, holds the shared iterative MUL/DIV datapath:
  - acc/rem, shift registers, counter
  - start/mode in, done/result out
- Top level holds the FSM, handshake, single-cycle ops and flags.

Test Plan:
- Reset then ADD: WIDTH=32, A=0xFFFFFFFF, B=1, Cond=0000 -> in_ready=1 after reset; one cycle after accept, out_valid=1, Z=0, Zero=1, Carry=1.
- MUL latency: A=12345, B=6789 -> out_valid exactly 33 edges after accept, Z=83810205; in_ready=0 throughout; in_valid pulses during busy are ignored.
- DIV/MOD: A=100, B=7 -> DIV Z=14, MOD Z=2 after 33 edges. A=5, B=0 -> DIV Z=0xFFFFFFFF, DivZero=1; MOD Z=5; both after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after SUB A=3, B=5 -> Z=0xFFFFFFFE, Carry=1, stable all 5 cycles; state returns to IDLE only on the out_ready edge.
- Reset mid-MUL: assert rst at iteration 10 -> next cycle out_valid=0, Z=0, in_ready=1; a fresh ADD 2+2 then returns Z=4.
- Shifts/compares and WIDTH=8 build: SHL A=1, B=40 -> Z=0; LT A=3, B=9 -> Z=1. With WIDTH=8, MUL A=20, B=20 -> Z=0x90 after 9 edges.
